// File: rtl/gomoku_game_manager.sv
// Gomoku game manager: NxN board, P players, cursor and turn control, and a sequential
// K-in-a-row scan that walks outward from each newly placed mark.
module gomoku_game_manager #(
    parameter int N = 5,
    parameter int K = 4,
    parameter int P = 2,
    parameter int SCORE_W = 4,
    localparam int CW = $clog2(N),
    localparam int PW = $clog2(P + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_l,
    input  logic                   btn_r,
    input  logic                   btn_u,
    input  logic                   btn_d,
    input  logic                   place,
    input  logic                   new_game,
    output logic [N*N*PW-1:0]      board_flat,
    output logic [CW-1:0]          cursor_row,
    output logic [CW-1:0]          cursor_col,
    output logic [PW-1:0]          cur_player,
    output logic [P-1:0]           turn_onehot,
    output logic                   busy,
    output logic                   illegal,
    output logic                   game_over,
    output logic                   cur_player_won,
    output logic                   draw,
    output logic [PW-1:0]          last_winner,
    output logic                   last_valid,
    output logic [P*SCORE_W-1:0]   score_flat
);
    localparam int CELLS = N * N;
    localparam int IW = $clog2(CELLS);
    localparam int MW = $clog2(CELLS + 1);
    localparam int CNTW = $clog2(K + 1);

    localparam logic [1:0] StPlay = 2'd0, StScan = 2'd1, StWon = 2'd2, StDraw = 2'd3;
    localparam logic [CW-1:0] LastRc = CW'(N - 1);
    localparam logic [PW-1:0] LastPl = PW'(P - 1);
    localparam logic [MW-1:0] AllCells = MW'(CELLS);
    localparam logic [CNTW-1:0] WinRun = CNTW'(K - 1);
    localparam logic signed [CW+1:0] SideS = (CW + 2)'(N);
    localparam logic signed [CW+1:0] Plus1 = (CW + 2)'(1);

    logic [5:0]         btn_q, btn_now, btn_edge;
    logic               e_l, e_r, e_u, e_d, e_place, e_new, restart;
    logic [PW-1:0]      board_q [CELLS];
    logic [CW-1:0]      row_q, col_q, row_nxt, col_nxt;
    logic [PW-1:0]      player_q, start_q, next_player, next_start, mark;
    logic [P-1:0]       turn_q;
    logic [MW-1:0]      moves_q;
    logic [1:0]         state_q;
    logic               illegal_q, valid_q;
    logic [PW-1:0]      winner_q;
    logic [SCORE_W-1:0] score_q [P];
    logic [IW-1:0]      widx, cand_idx;

    // Scan state: origin, current walk position, direction 0..3, backward half, run count
    logic [CW-1:0]          org_r_q, org_c_q, pos_r_q, pos_c_q;
    logic [1:0]             dir_q;
    logic                   back_q;
    logic [CNTW-1:0]        cnt_q, cnt_inc;
    logic signed [CW+1:0]   dr, dc, nr, nc;
    logic                   in_b, own, win_now;

    function automatic logic [P-1:0] to_onehot(input logic [PW-1:0] p);
        logic [P-1:0] v;
        v = '0;
        for (int i = 0; i < P; i++) begin
            if (p == PW'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    assign btn_now  = {new_game, place, btn_d, btn_u, btn_r, btn_l};
    assign btn_edge = btn_now & ~btn_q;
    assign e_l      = btn_edge[0];
    assign e_r      = btn_edge[1];
    assign e_u      = btn_edge[2];
    assign e_d      = btn_edge[3];
    assign e_place  = btn_edge[4];
    assign e_new    = btn_edge[5];
    assign restart  = e_new || (e_place && (state_q == StWon || state_q == StDraw));

    assign mark        = player_q + PW'(1);
    assign next_player = (player_q == LastPl) ? '0 : player_q + PW'(1);
    assign next_start  = (start_q == LastPl) ? '0 : start_q + PW'(1);
    assign widx        = IW'(int'(row_q) * N + int'(col_q));

    always_comb begin
        row_nxt = row_q;
        col_nxt = col_q;
        if (e_u && !e_d) row_nxt = (row_q == '0) ? LastRc : row_q - 1'b1;
        else if (e_d && !e_u) row_nxt = (row_q == LastRc) ? '0 : row_q + 1'b1;
        if (e_l && !e_r) col_nxt = (col_q == '0) ? LastRc : col_q - 1'b1;
        else if (e_r && !e_l) col_nxt = (col_q == LastRc) ? '0 : col_q + 1'b1;
    end

    // Candidate cell one step from the walk position along the current direction
    always_comb begin
        dr = '0;
        dc = '0;
        unique case (dir_q)
            2'd0: dc = Plus1;
            2'd1: dr = Plus1;
            2'd2: begin dr = Plus1; dc = Plus1; end
            default: begin dr = Plus1; dc = -Plus1; end
        endcase
        if (back_q) begin
            dr = -dr;
            dc = -dc;
        end
        nr       = $signed({2'b00, pos_r_q}) + dr;
        nc       = $signed({2'b00, pos_c_q}) + dc;
        in_b     = !nr[CW+1] && (nr < SideS) && !nc[CW+1] && (nc < SideS);
        cand_idx = in_b ? IW'(int'(nr[CW-1:0]) * N + int'(nc[CW-1:0])) : '0;
        own      = in_b && (board_q[cand_idx] == mark);
        cnt_inc  = cnt_q + 1'b1;
        win_now  = own && (cnt_inc >= WinRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q     <= '0;
            for (int i = 0; i < CELLS; i++) board_q[i] <= '0;
            row_q     <= '0;
            col_q     <= '0;
            player_q  <= '0;
            start_q   <= '0;
            turn_q    <= to_onehot('0);
            moves_q   <= '0;
            state_q   <= StPlay;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
            winner_q  <= '0;
            for (int p = 0; p < P; p++) score_q[p] <= '0;
            org_r_q   <= '0;
            org_c_q   <= '0;
            pos_r_q   <= '0;
            pos_c_q   <= '0;
            dir_q     <= '0;
            back_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            btn_q     <= btn_now;
            illegal_q <= 1'b0;
            if (restart) begin
                for (int i = 0; i < CELLS; i++) board_q[i] <= '0;
                moves_q  <= '0;
                row_q    <= '0;
                col_q    <= '0;
                start_q  <= next_start;
                player_q <= next_start;
                turn_q   <= to_onehot(next_start);
                state_q  <= StPlay;
            end else begin
                unique case (state_q)
                    StPlay: begin
                        row_q <= row_nxt;
                        col_q <= col_nxt;
                        if (e_place) begin
                            if (board_q[widx] != '0) begin
                                illegal_q <= 1'b1;
                            end else begin
                                board_q[widx] <= mark;
                                moves_q <= moves_q + 1'b1;
                                org_r_q <= row_q;
                                org_c_q <= col_q;
                                pos_r_q <= row_q;
                                pos_c_q <= col_q;
                                dir_q   <= '0;
                                back_q  <= 1'b0;
                                cnt_q   <= '0;
                                state_q <= StScan;
                            end
                        end
                    end
                    StScan: begin
                        if (win_now) begin
                            state_q  <= StWon;
                            winner_q <= player_q;
                            valid_q  <= 1'b1;
                            for (int p = 0; p < P; p++) begin
                                if (player_q == PW'(p) && score_q[p] != '1)
                                    score_q[p] <= score_q[p] + 1'b1;
                            end
                        end else if (own) begin
                            pos_r_q <= nr[CW-1:0];
                            pos_c_q <= nc[CW-1:0];
                            cnt_q   <= cnt_inc;
                        end else if (!back_q) begin
                            back_q  <= 1'b1;
                            pos_r_q <= org_r_q;
                            pos_c_q <= org_c_q;
                        end else if (dir_q != 2'd3) begin
                            dir_q   <= dir_q + 1'b1;
                            back_q  <= 1'b0;
                            pos_r_q <= org_r_q;
                            pos_c_q <= org_c_q;
                            cnt_q   <= '0;
                        end else if (moves_q == AllCells) begin
                            state_q <= StDraw;
                        end else begin
                            player_q <= next_player;
                            turn_q   <= to_onehot(next_player);
                            state_q  <= StPlay;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        board_flat = '0;
        for (int i = 0; i < CELLS; i++) board_flat[i*PW +: PW] = board_q[i];
        score_flat = '0;
        for (int p = 0; p < P; p++) score_flat[p*SCORE_W +: SCORE_W] = score_q[p];
    end

    assign cursor_row     = row_q;
    assign cursor_col     = col_q;
    assign cur_player     = player_q;
    assign turn_onehot    = turn_q;
    assign busy           = (state_q == StScan);
    assign illegal        = illegal_q;
    assign game_over      = (state_q == StWon) || (state_q == StDraw);
    assign cur_player_won = (state_q == StWon);
    assign draw           = (state_q == StDraw);
    assign last_winner    = winner_q;
    assign last_valid     = valid_q;
endmodule

// File: tb/tb_gomoku_game_manager.sv
`timescale 1ns/1ps
// Bench for gomoku_game_manager: cursor vector table plus scripted games, with expected
// values taken from a behavioural board model through an expectation queue.
module tb_gomoku_game_manager;
    localparam int N  = 5;
    localparam int K  = 4;
    localparam int SW = 4;
    localparam int CW = $clog2(N);
    localparam int PW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
    logic place = 1'b0, new_game = 1'b0;
    logic use_b = 1'b0;

    logic [N*N*PW-1:0] board_a, board_b;
    logic [CW-1:0]     row_a, col_a, row_b, col_b;
    logic [PW-1:0]     player_a, player_b, winner_a, winner_b;
    logic [1:0]        turn_a;
    logic [2:0]        turn_b;
    logic              busy_a, illegal_a, over_a, won_a, draw_a, lvalid_a;
    logic              busy_b, illegal_b, over_b, won_b, draw_b, lvalid_b;
    logic [2*SW-1:0]   score_a;
    logic [3*SW-1:0]   score_b;

    always #5 clk = ~clk;

    gomoku_game_manager #(.N(N), .K(K), .P(2), .SCORE_W(SW)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .place(place), .new_game(new_game), .board_flat(board_a), .cursor_row(row_a),
        .cursor_col(col_a), .cur_player(player_a), .turn_onehot(turn_a), .busy(busy_a),
        .illegal(illegal_a), .game_over(over_a), .cur_player_won(won_a), .draw(draw_a),
        .last_winner(winner_a), .last_valid(lvalid_a), .score_flat(score_a)
    );

    gomoku_game_manager #(.N(N), .K(K), .P(3), .SCORE_W(SW)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .place(place), .new_game(new_game), .board_flat(board_b), .cursor_row(row_b),
        .cursor_col(col_b), .cur_player(player_b), .turn_onehot(turn_b), .busy(busy_b),
        .illegal(illegal_b), .game_over(over_b), .cur_player_won(won_b), .draw(draw_b),
        .last_winner(winner_b), .last_valid(lvalid_b), .score_flat(score_b)
    );

    logic [63:0] board_v, row_v, col_v, player_v, turn_v, score_v, winner_v;
    logic [63:0] busy_v, illegal_v, over_v, won_v, draw_v, lvalid_v;
    assign board_v   = use_b ? 64'(board_b)   : 64'(board_a);
    assign row_v     = use_b ? 64'(row_b)     : 64'(row_a);
    assign col_v     = use_b ? 64'(col_b)     : 64'(col_a);
    assign player_v  = use_b ? 64'(player_b)  : 64'(player_a);
    assign turn_v    = use_b ? 64'(turn_b)    : 64'(turn_a);
    assign score_v   = use_b ? 64'(score_b)   : 64'(score_a);
    assign winner_v  = use_b ? 64'(winner_b)  : 64'(winner_a);
    assign busy_v    = use_b ? 64'(busy_b)    : 64'(busy_a);
    assign illegal_v = use_b ? 64'(illegal_b) : 64'(illegal_a);
    assign over_v    = use_b ? 64'(over_b)    : 64'(over_a);
    assign won_v     = use_b ? 64'(won_b)     : 64'(won_a);
    assign draw_v    = use_b ? 64'(draw_b)    : 64'(draw_a);
    assign lvalid_v  = use_b ? 64'(lvalid_b)  : 64'(lvalid_a);

    typedef struct { string name; logic [63:0] exp; } sb_t;
    sb_t sbq[$];
    int checks = 0;
    int errors = 0;

    typedef struct { bit l; bit r; bit u; bit d; int row; int col; string name; } cur_vec_t;

    // Behavioural model
    int mb [N*N];
    int mr, mc, mplayer, mstart, mmoves, mp, mwinner;
    int mscore [3];
    bit mvalid;

    function automatic bit has_line(input int pl);
        int drs [4] = '{0, 1, 1, 1};
        int dcs [4] = '{1, 0, 1, -1};
        bit ok;
        int rr, cc;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                for (int d = 0; d < 4; d++) begin
                    ok = 1'b1;
                    for (int k = 0; k < K; k++) begin
                        rr = r + k * drs[d];
                        cc = c + k * dcs[d];
                        if (rr < 0 || rr >= N || cc < 0 || cc >= N) ok = 1'b0;
                        else if (mb[rr*N + cc] != pl + 1) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic logic [63:0] model_board();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < N*N; i++) v[i*PW +: PW] = PW'(mb[i]);
        return v;
    endfunction

    function automatic logic [63:0] model_score();
        logic [63:0] v;
        v = '0;
        for (int p = 0; p < mp; p++) v[p*SW +: SW] = SW'(mscore[p]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N*N; i++) mb[i] = 0;
        for (int p = 0; p < 3; p++) mscore[p] = 0;
        mr = 0; mc = 0; mplayer = 0; mstart = 0; mmoves = 0; mwinner = 0; mvalid = 1'b0;
    endtask

    task automatic model_new();
        for (int i = 0; i < N*N; i++) mb[i] = 0;
        mr = 0; mc = 0; mmoves = 0;
        mstart = (mstart + 1) % mp;
        mplayer = mstart;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string n, input logic [63:0] e);
        sb_t s;
        s.name = n;
        s.exp = e;
        sbq.push_back(s);
    endtask

    task automatic pop_cmp(input logic [63:0] got);
        sb_t s;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0h with no expectation queued", got);
        end else begin
            s = sbq.pop_front();
            if (got !== s.exp) begin
                errors++;
                $display("FAIL %s: got %0h, expected %0h", s.name, got, s.exp);
            end
        end
    endtask

    task automatic push_state();
        push("board", model_board());
        push("cursor_row", 64'(mr));
        push("cursor_col", 64'(mc));
        push("cur_player", 64'(mplayer));
        push("turn_onehot", 64'(1) << mplayer);
        push("score", model_score());
        push("last_valid", 64'(mvalid));
        push("last_winner", 64'(mwinner));
    endtask

    task automatic pop_state();
        pop_cmp(board_v); pop_cmp(row_v); pop_cmp(col_v); pop_cmp(player_v);
        pop_cmp(turn_v); pop_cmp(score_v); pop_cmp(lvalid_v); pop_cmp(winner_v);
    endtask

    task automatic push_flags(input bit over, input bit won, input bit dr, input bit bsy);
        push("game_over", 64'(over));
        push("cur_player_won", 64'(won));
        push("draw", 64'(dr));
        push("busy", 64'(bsy));
        push("illegal", 64'(0));
    endtask

    task automatic pop_flags();
        pop_cmp(over_v); pop_cmp(won_v); pop_cmp(draw_v); pop_cmp(busy_v); pop_cmp(illegal_v);
    endtask

    task automatic press(input int which);
        btn_l = (which == 0); btn_r = (which == 1); btn_u = (which == 2); btn_d = (which == 3);
        cyc();
        btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
        cyc();
    endtask

    task automatic goto_cell(input int r, input int c);
        while (mc != c) begin press(1); mc = (mc + 1) % N; end
        while (mr != r) begin press(3); mr = (mr + 1) % N; end
    endtask

    task automatic start_new_game();
        new_game = 1'b1;
        cyc();
        new_game = 1'b0;
        cyc();
        model_new();
        push_state();
        push_flags(0, 0, 0, 0);
        pop_state();
        pop_flags();
    endtask

    task automatic do_place();
        int idx, n;
        bit w, full;
        idx = mr * N + mc;
        if (mb[idx] != 0) begin
            push("illegal_pulse", 64'(1));
            push("board_kept", model_board());
            push("player_kept", 64'(mplayer));
            place = 1'b1;
            cyc();
            pop_cmp(illegal_v); pop_cmp(board_v); pop_cmp(player_v);
            place = 1'b0;
            push("illegal_one_cycle", 64'(0));
            cyc();
            pop_cmp(illegal_v);
            return;
        end
        mb[idx] = mplayer + 1;
        mmoves++;
        w = has_line(mplayer);
        full = (mmoves == N*N);
        push("board_write", model_board());
        push("busy_start", 64'(1));
        place = 1'b1;
        cyc();
        pop_cmp(board_v);
        pop_cmp(busy_v);
        place = 1'b0;
        if (w) begin
            mwinner = mplayer;
            mvalid = 1'b1;
            if (mscore[mplayer] < (1 << SW) - 1) mscore[mplayer]++;
        end else if (!full) begin
            mplayer = (mplayer + 1) % mp;
        end
        push_state();
        push_flags(w || full, w, !w && full, 0);
        n = 0;
        while (busy_v[0] && n < 60) begin
            cyc();
            n++;
        end
        checks++;
        if (n < 1 || n > 8*(K-1) + 4) begin
            errors++;
            $display("FAIL scan_latency: got %0d busy cycles, required 1..%0d", n, 8*(K-1) + 4);
        end
        pop_state();
        pop_flags();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cur_vec_t cv [7];
        int t1r [7] = '{0, 4, 0, 4, 0, 4, 0};
        int t1c [7] = '{0, 0, 1, 1, 2, 2, 3};
        int t5r [11] = '{4, 3, 1, 4, 2, 1, 3, 1, 2, 2, 0};
        int t5c [11] = '{4, 0, 0, 3, 1, 1, 4, 2, 0, 4, 3};
        int acells[$], bcells[$];

        cv[0] = '{1, 0, 0, 0, 0, 4, "left_wrap"};
        cv[1] = '{0, 0, 1, 0, 4, 4, "up_wrap"};
        cv[2] = '{1, 1, 0, 0, 4, 4, "lr_cancel"};
        cv[3] = '{0, 0, 1, 1, 4, 4, "ud_cancel"};
        cv[4] = '{0, 1, 0, 0, 4, 0, "right_wrap"};
        cv[5] = '{0, 0, 0, 1, 0, 0, "down_wrap"};
        cv[6] = '{0, 0, 0, 1, 1, 0, "down_step"};

        mp = 2;
        model_reset();
        repeat (3) cyc();
        push_state();
        push_flags(0, 0, 0, 0);
        pop_state();
        pop_flags();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Horizontal win by player 0
        for (int i = 0; i < 7; i++) begin
            goto_cell(t1r[i], t1c[i]);
            do_place();
        end

        // Cursor vectors
        start_new_game();
        for (int i = 0; i < 7; i++) begin
            btn_l = cv[i].l; btn_r = cv[i].r; btn_u = cv[i].u; btn_d = cv[i].d;
            cyc();
            btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
            mr = cv[i].row;
            mc = cv[i].col;
            push({cv[i].name, "_row"}, 64'(mr));
            push({cv[i].name, "_col"}, 64'(mc));
            cyc();
            pop_cmp(row_v);
            pop_cmp(col_v);
        end
        btn_r = 1'b1;
        repeat (10) cyc();
        btn_r = 1'b0;
        cyc();
        mc = (mc + 1) % N;
        push("hold_right_row", 64'(mr));
        push("hold_right_col", 64'(mc));
        pop_cmp(row_v);
        pop_cmp(col_v);

        // Occupied-cell placement
        do_place();
        do_place();

        // Draw: pattern with no 4-in-a-row anywhere
        start_new_game();
        for (int i = 0; i < N*N; i++) begin
            if (((((i % N) == 2 || (i % N) == 3) ? 1 : 0) ^ ((i / N) & 1)) == 0)
                acells.push_back(i);
            else
                bcells.push_back(i);
        end
        for (int k = 0; k < 13; k++) begin
            goto_cell(acells[k] / N, acells[k] % N);
            do_place();
            if (k < 12) begin
                goto_cell(bcells[k] / N, bcells[k] % N);
                do_place();
            end
        end
        place = 1'b1;
        cyc();
        place = 1'b0;
        cyc();
        model_new();
        push_state();
        push_flags(0, 0, 0, 0);
        pop_state();
        pop_flags();

        // Asynchronous reset during a scan
        goto_cell(2, 2);
        place = 1'b1;
        cyc();
        place = 1'b0;
        push("busy_before_reset", 64'(1));
        pop_cmp(busy_v);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        push_state();
        push_flags(0, 0, 0, 0);
        pop_state();
        pop_flags();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Three players: anti-diagonal win by player 1, then abort mid-scan
        use_b = 1'b1;
        mp = 3;
        for (int i = 0; i < 11; i++) begin
            goto_cell(t5r[i], t5c[i]);
            do_place();
        end
        start_new_game();
        place = 1'b1;
        cyc();
        place = 1'b0;
        push("busy_before_abort", 64'(1));
        pop_cmp(busy_v);
        new_game = 1'b1;
        cyc();
        new_game = 1'b0;
        model_new();
        push_state();
        push_flags(0, 0, 0, 0);
        pop_state();
        pop_flags();
        repeat (30) cyc();
        push_state();
        push_flags(0, 0, 0, 0);
        pop_state();
        pop_flags();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
